// File: rtl/gtp_pll_seq.sv
// Power-up, reset and lock-qualification sequencer for a GTP common-block PLL.
// Retries on lock timeout and declares failure after MAX_RETRY attempts.
module gtp_pll_seq #(
    parameter int PD_CYCLES    = 16,
    parameter int RST_CYCLES   = 8,
    parameter int LOCK_TIMEOUT = 4096,
    parameter int MAX_RETRY    = 3,
    parameter int LOCK_FILT    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       pll_lock,
    output logic       pll_pd,
    output logic       pll_reset,
    output logic       pll_locken,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [2:0] state
);

    localparam int MAX_AB = (PD_CYCLES > RST_CYCLES) ? PD_CYCLES : RST_CYCLES;
    localparam int MAX_V  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int CW     = $clog2(MAX_V) + 1;
    localparam int FW     = $clog2(LOCK_FILT) + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PWRDN     = 3'd1,
        S_RESET     = 3'd2,
        S_WAIT_LOCK = 3'd3,
        S_LOCKED    = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    logic [1:0]    r_rst_sync;
    logic          r_lock_meta;
    logic          r_lock_sync;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [FW-1:0] r_filt;
    logic [1:0]    r_retry;
    logic          r_pd;
    logic          r_reset;
    logic          r_locken;
    logic          r_ready;
    logic          r_fail;

    state_t        w_next;
    logic          w_lock_qual;
    logic          w_timeout;
    logic [FW-1:0] w_filt_inc;

    // Release of rst_n is re-timed so the FSM first moves on the third edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_sync <= r_lock_meta;
        end
    end

    always_comb begin
        w_filt_inc  = (r_filt == '1) ? r_filt : r_filt + 1'b1;
        w_lock_qual = r_lock_sync && (r_filt >= FW'(LOCK_FILT - 1));
        w_timeout   = (r_cnt >= CW'(LOCK_TIMEOUT - 1));
        w_next      = r_state;
        if (!enable) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:      w_next = S_PWRDN;
                S_PWRDN:     if (r_cnt >= CW'(PD_CYCLES - 1)) w_next = S_RESET;
                S_RESET:     if (r_cnt >= CW'(RST_CYCLES - 1)) w_next = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    // A qualified lock takes precedence over a coincident timeout.
                    if (w_lock_qual) begin
                        w_next = S_LOCKED;
                    end else if (w_timeout) begin
                        w_next = (r_retry < 2'(MAX_RETRY)) ? S_PWRDN : S_FAIL;
                    end
                end
                S_LOCKED:    if (!r_lock_sync) w_next = S_PWRDN;
                S_FAIL:      w_next = S_FAIL;
                default:     w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_filt   <= '0;
            r_retry  <= 2'd0;
            r_pd     <= 1'b1;
            r_reset  <= 1'b0;
            r_locken <= 1'b0;
            r_ready  <= 1'b0;
            r_fail   <= 1'b0;
        end else if (r_rst_sync[1]) begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_filt <= (r_state == S_WAIT_LOCK && w_next == S_WAIT_LOCK && r_lock_sync)
                      ? w_filt_inc : '0;
            // Timeout retries count up; any other entry into PWRDN starts a fresh bring-up.
            if (r_state == S_WAIT_LOCK && w_next == S_PWRDN) begin
                r_retry <= r_retry + 1'b1;
            end else if (w_next == S_PWRDN && r_state != S_PWRDN) begin
                r_retry <= 2'd0;
            end
            r_pd     <= (w_next == S_IDLE) || (w_next == S_PWRDN) || (w_next == S_FAIL);
            r_reset  <= (w_next == S_RESET);
            r_locken <= (w_next == S_WAIT_LOCK) || (w_next == S_LOCKED);
            r_ready  <= (w_next == S_LOCKED);
            r_fail   <= (w_next == S_FAIL);
        end
    end

    assign pll_pd     = r_pd;
    assign pll_reset  = r_reset;
    assign pll_locken = r_locken;
    assign ready      = r_ready;
    assign fail       = r_fail;
    assign retry_cnt  = r_retry;
    assign state      = r_state;

endmodule

// File: tb/tb_gtp_pll_seq.sv
// Directed self-checking bench for gtp_pll_seq with default parameters.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_gtp_pll_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       pll_lock;
    logic       pll_pd;
    logic       pll_reset;
    logic       pll_locken;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    gtp_pll_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .pll_lock   (pll_lock),
        .pll_pd     (pll_pd),
        .pll_reset  (pll_reset),
        .pll_locken (pll_locken),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic en, input logic lock);
        enable   = en;
        pll_lock = lock;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic logic selSig(input int sel);
        case (sel)
            0:       return pll_pd;
            1:       return pll_reset;
            default: return (state == 3'd3);
        endcase
    endfunction

    // Counts consecutive falling-edge samples (starting now) where the selected signal is high.
    task automatic countHigh(input int sel, input int maxCyc, output int n);
        n = 0;
        while (selSig(sel) === 1'b1 && n < maxCyc) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic waitState(input logic [2:0] s, input int maxCyc, input string tag);
        int n = 0;
        while (state !== s && n < maxCyc) begin
            n++;
            @(negedge clk);
        end
        checkOutput(tag, state, s);
    endtask

    initial begin
        int n;
        int phase;
        logic sawLocked;

        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_state", state, 0);
        checkOutput("rst_pd", pll_pd, 1);
        checkOutput("rst_reset", pll_reset, 0);
        checkOutput("rst_locken", pll_locken, 0);
        checkOutput("rst_ready", ready, 0);
        checkOutput("rst_fail", fail, 0);
        checkOutput("rst_retry", retry_cnt, 0);

        // Normal bring-up with lock arriving 100 cycles into WAIT_LOCK
        applyStimulus(1'b1, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_edge1_state", state, 0);
        @(negedge clk);
        checkOutput("rel_edge2_state", state, 0);
        @(negedge clk);
        checkOutput("rel_edge3_state", state, 1);
        countHigh(0, 100, n);
        checkOutput("pd_cycles", n, 16);
        checkOutput("reset_first_state", state, 2);
        countHigh(1, 100, n);
        checkOutput("reset_cycles", n, 8);
        checkOutput("wait_state", state, 3);
        checkOutput("wait_locken", pll_locken, 1);
        checkOutput("wait_pd", pll_pd, 0);
        repeat (100) @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        $display("[TB] ready rose %0d cycles into WAIT_LOCK", 100 + n);
        checkOutput("ready_latency_in_range", (100 + n >= 105) && (100 + n <= 107), 1);
        checkOutput("locked_state", state, 4);
        checkOutput("locked_retry", retry_cnt, 0);
        checkOutput("locked_locken", pll_locken, 1);

        // One-cycle lock glitch while LOCKED
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        n = 1;
        while (ready === 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("glitch_ready_within3", n <= 3, 1);
        checkOutput("glitch_state", state, 1);
        checkOutput("glitch_retry", retry_cnt, 0);
        waitState(3'd4, 200, "relock_state");
        checkOutput("relock_ready", ready, 1);

        // Enable dropped from LOCKED, then during RESET
        applyStimulus(1'b0, 1'b1);
        @(negedge clk);
        checkOutput("dis_locked_state", state, 0);
        checkOutput("dis_locked_ready", ready, 0);
        checkOutput("dis_locked_pd", pll_pd, 1);
        checkOutput("dis_locked_locken", pll_locken, 0);
        applyStimulus(1'b1, 1'b0);
        waitState(3'd2, 100, "reach_reset");
        checkOutput("in_reset_pllreset", pll_reset, 1);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("dis_reset_state", state, 0);
        checkOutput("dis_reset_pllreset", pll_reset, 0);
        checkOutput("dis_reset_pd", pll_pd, 1);

        // Lock toggling 3 high / 1 low must never qualify
        applyStimulus(1'b1, 1'b0);
        waitState(3'd3, 100, "toggle_reach_wait");
        phase = 0;
        sawLocked = 1'b0;
        n = 0;
        while (state === 3'd3 && n < 6000) begin
            applyStimulus(1'b1, phase != 3);
            phase = (phase + 1) % 4;
            @(negedge clk);
            if (state === 3'd4) sawLocked = 1'b1;
            n++;
        end
        checkOutput("toggle_never_locked", sawLocked, 0);
        checkOutput("toggle_wait_cycles", n, 4096);
        checkOutput("toggle_retry_state", state, 1);
        checkOutput("toggle_retry_cnt", retry_cnt, 1);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("toggle_idle", state, 0);

        // Lock never arrives: three retries, then FAIL
        applyStimulus(1'b1, 1'b0);
        for (int t = 1; t <= 4; t++) begin
            waitState(3'd3, 100, "timeout_reach_wait");
            countHigh(2, 6000, n);
            checkOutput("timeout_wait_cycles", n, 4096);
            if (t < 4) begin
                checkOutput("timeout_retry_state", state, 1);
                checkOutput("timeout_retry_cnt", retry_cnt, t);
                if (t == 1) begin
                    countHigh(0, 100, n);
                    checkOutput("retry_pd_cycles", n, 16);
                end
            end
        end
        checkOutput("fail_state", state, 5);
        checkOutput("fail_flag", fail, 1);
        checkOutput("fail_pd", pll_pd, 1);
        checkOutput("fail_ready", ready, 0);
        checkOutput("fail_retry", retry_cnt, 3);
        repeat (5) @(negedge clk);
        checkOutput("fail_sticky", fail, 1);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("fail_exit_state", state, 0);
        checkOutput("fail_exit_flag", fail, 0);

        // Asynchronous reset while LOCKED, then restart with enable held
        applyStimulus(1'b1, 1'b1);
        waitState(3'd4, 200, "prereset_locked");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_state", state, 0);
        checkOutput("async_rst_pd", pll_pd, 1);
        checkOutput("async_rst_ready", ready, 0);
        checkOutput("async_rst_locken", pll_locken, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rerel_edge1_state", state, 0);
        @(negedge clk);
        checkOutput("rerel_edge2_state", state, 0);
        @(negedge clk);
        checkOutput("rerel_edge3_state", state, 1);
        waitState(3'd4, 200, "rerel_relock");
        checkOutput("rerel_ready", ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
